image_expander: RTL and testbench

- Inverse of the ROI cropper at the front of the canny pipeline.
- Consumes a raster-ordered stream containing only the pixels inside the reduced-image rectangle (STARTING_X..ENDING_X, STARTING_Y..ENDING_Y).
- Re-emits a full WIDTH x HEIGHT raster stream, with FILL_VALUE substituted outside the rectangle.
- Sits between the canny/hough result FIFO and the full-frame output FIFO that feeds the image writer / testbench dump.

---
 rtl/image_pkg.sv | 14 +
 rtl/raster_counter.sv | 37 +++
 rtl/image_expander.sv | 104 ++++++++++
 tb/tb_image_expander.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared frame geometry and image_expander state encoding
package image_pkg;

  localparam int WIDTH      = 1280;
  localparam int HEIGHT     = 720;
  localparam int STARTING_X = 123;
  localparam int STARTING_Y = 31;
  localparam int ENDING_X   = 1157;
  localparam int ENDING_Y   = 256;
  localparam int DATA_WIDTH = 24;

  typedef enum logic [1:0] {IDLE, OUTPUT} state_types;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster x/y position with a last-pixel flag
module raster_counter #(
  parameter int WIDTH  = image_pkg::WIDTH,
  parameter int HEIGHT = image_pkg::HEIGHT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic                      last
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Holds at the last pixel; the owner clears it when the next frame starts.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_expander.sv
// rtl/image_expander.sv - re-expands a ROI-only raster stream to a full frame,
// substituting FILL_VALUE outside the rectangle
module image_expander #(
  parameter int                        WIDTH      = image_pkg::WIDTH,
  parameter int                        HEIGHT     = image_pkg::HEIGHT,
  parameter int                        STARTING_X = image_pkg::STARTING_X,
  parameter int                        STARTING_Y = image_pkg::STARTING_Y,
  parameter int                        ENDING_X   = image_pkg::ENDING_X,
  parameter int                        ENDING_Y   = image_pkg::ENDING_Y,
  parameter int                        DATA_WIDTH = image_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]     FILL_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  frame_done,
  output logic                  busy
);

  import image_pkg::*;

  state_types                  state;
  state_types                  next_state;
  logic [$clog2(WIDTH)-1:0]    x;
  logic [$clog2(HEIGHT)-1:0]   y;
  logic                        last;
  logic                        start;
  logic                        advance;
  logic                        in_roi;

  assign in_roi = (int'(x) >= STARTING_X) && (int'(x) <= ENDING_X) &&
                  (int'(y) >= STARTING_Y) && (int'(y) <= ENDING_Y);

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (start),
    .advance (advance),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are gated by reset so an abandoned frame moves no data.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    advance    = 1'b0;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    frame_done = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!in_empty) begin
            next_state = OUTPUT;
            start      = 1'b1;
          end
        end
        OUTPUT: begin
          busy = 1'b1;
          if (!out_full) begin
            if (!in_roi) begin
              out_wr_en = 1'b1;
              out_din   = FILL_VALUE;
              advance   = 1'b1;
            end else if (!in_empty) begin
              in_rd_en  = 1'b1;
              out_wr_en = 1'b1;
              out_din   = in_dout;
              advance   = 1'b1;
            end
          end
          if (advance && last) begin
            frame_done = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_expander.sv
// tb/tb_image_expander.sv - randomized self-checking bench for image_expander
module tb_image_expander;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int SX   = 2;
  localparam int EX   = 5;
  localparam int SY   = 1;
  localparam int EY   = 2;
  localparam int DW   = 24;
  localparam int N    = W * H;
  localparam int NROI = (EX - SX + 1) * (EY - SY + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          in_rd_en;
  logic          in_empty;
  logic [DW-1:0] in_dout;
  logic          out_wr_en;
  logic          out_full;
  logic [DW-1:0] out_din;
  logic          frame_done;
  logic          busy;

  always #5 clock = ~clock;

  image_expander #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .STARTING_X (SX),
    .STARTING_Y (SY),
    .ENDING_X   (EX),
    .ENDING_Y   (EY),
    .DATA_WIDTH (DW),
    .FILL_VALUE ('0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .frame_done (frame_done),
    .busy       (busy)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] frame_px[$];
  logic [DW-1:0] cap[N];
  int            avail_mode = 0;
  int            full_mode = 0;
  int            cyc = 0;
  bit            rst_req = 1'b1;
  bit            m_active = 1'b0;
  int            m_idx = 0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  int            frames_done = 0;

  function automatic bit roi_at(int i);
    int x = i % W;
    int y = i / W;
    return (x >= SX) && (x <= EX) && (y >= SY) && (y <= EY);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void end_of_frame();
    logic [DW-1:0] px[NROI];
    logic [DW-1:0] e;
    int k = 0;
    chk("frame_writes", wr_cnt, N);
    chk("frame_pops", rd_cnt, NROI);
    for (int j = 0; j < NROI; j++) px[j] = (frame_px.size() > 0) ? frame_px.pop_front() : '0;
    for (int i = 0; i < N; i++) begin
      e = '0;
      if (roi_at(i)) begin
        e = px[k];
        k++;
      end
      chk($sformatf("image_px%0d", i), cap[i], e);
    end
  endfunction

  task automatic step();
    bit vis, roi, go;
    bit e_wr, e_rd, e_fd, e_busy;
    logic [DW-1:0] e_din;
    @(negedge clock);
    cyc++;
    reset = rst_req;
    case (full_mode)
      0: out_full = 1'b0;
      1: out_full = cyc[0];
      default: out_full = ($urandom_range(0, 3) == 0);
    endcase
    vis = (q.size() > 0);
    case (avail_mode)
      1: vis = vis && (cyc % 3 == 0);
      2: if (m_active) vis = 1'b0;
      3: vis = vis && ($urandom_range(0, 9) < 6);
      default: ;
    endcase
    in_empty = !vis;
    in_dout  = vis ? q[0] : DW'($urandom);
    #1;
    e_wr = 1'b0; e_rd = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_din = '0;
    if (!reset && m_active) begin
      roi    = roi_at(m_idx);
      go     = !out_full && (!roi || !in_empty);
      e_busy = 1'b1;
      e_wr   = go;
      e_rd   = go && roi;
      e_din  = (go && roi) ? in_dout : '0;
      e_fd   = go && (m_idx == N - 1);
    end
    chk("out_wr_en", out_wr_en, e_wr);
    chk("in_rd_en", in_rd_en, e_rd);
    chk("out_din", out_din, e_din);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
    if (in_rd_en && q.size() > 0) void'(q.pop_front());
    if (in_rd_en) rd_cnt++;
    if (out_wr_en) begin
      if (wr_cnt < N) cap[wr_cnt] = out_din;
      wr_cnt++;
    end
    if (reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (!in_empty) begin
        m_active = 1'b1;
        m_idx    = 0;
        wr_cnt   = 0;
        rd_cnt   = 0;
      end
    end else if (e_wr) begin
      if (e_fd) begin
        m_active = 1'b0;
        frames_done++;
        end_of_frame();
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic run_frame(int budget);
    int f0 = frames_done;
    int n = 0;
    while (frames_done == f0 && n < budget) begin
      step();
      n++;
    end
    if (frames_done == f0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done after %0d cycles, expected one", budget);
    end
  endtask

  task automatic push(logic [DW-1:0] v);
    q.push_back(v);
    frame_px.push_back(v);
  endtask

  initial begin
    int n;
    int roi_total;
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;

    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_wr", out_wr_en, 0);
    rst_req = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    roi_total = 0;
    for (int i = 0; i < N; i++) roi_total += int'(roi_at(i));
    chk("model_roi_count", roi_total, 8);

    // free flow
    for (int i = 1; i <= 8; i++) push(DW'(i));
    run_frame(200);
    chk("free_px10", cap[10], 1);
    chk("free_px13", cap[13], 4);
    chk("free_px18", cap[18], 5);
    chk("free_px21", cap[21], 8);
    chk("free_px9", cap[9], 0);
    chk("free_px14", cap[14], 0);
    chk("free_px31", cap[31], 0);

    // input underflow inside the ROI
    avail_mode = 1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    run_frame(400);
    chk("under_px10", cap[10], 1);
    chk("under_px21", cap[21], 8);

    // output backpressure
    avail_mode = 0;
    full_mode  = 1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    run_frame(400);
    chk("bp_px18", cap[18], 5);
    full_mode = 0;

    // fill pixels need no input
    avail_mode = 2;
    for (int i = 0; i < 8; i++) push(DW'(32'h40 + i));
    repeat (40) step();
    chk("stall_writes", wr_cnt, 10);
    chk("stall_pops", rd_cnt, 0);
    chk("stall_busy", busy, 1);
    avail_mode = 0;
    run_frame(200);

    // reset mid-frame
    for (int i = 0; i < 8; i++) push(DW'(32'h100 + i));
    n = 0;
    while (!(m_active && wr_cnt == 15) && n < 200) begin
      step();
      n++;
    end
    chk("midframe_reached", wr_cnt, 15);
    rst_req = 1'b1;
    q.delete();
    frame_px.delete();
    step();
    rst_req = 1'b0;
    step();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_wr", out_wr_en, 0);
    chk("post_reset_rd", in_rd_en, 0);
    chk("post_reset_din", out_din, 0);
    chk("post_reset_fd", frame_done, 0);
    for (int i = 0; i < 8; i++) push(DW'(32'h200 + i));
    run_frame(200);
    chk("restart_px10", cap[10], 32'h200);
    chk("restart_px21", cap[21], 32'h207);

    // randomized back-to-back frames
    avail_mode = 3;
    full_mode  = 2;
    for (int i = 0; i < 3 * NROI; i++) push(DW'($urandom));
    repeat (3) run_frame(800);

    avail_mode = 0;
    full_mode  = 0;
    repeat (3) step();
    chk("final_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
